booth_product_accumulator: RTL
==============================

// Module: booth_product_accumulator
// PURPOSE
//  Downstream consumer of the 32x32 signed Booth multiplier's 64-bit product (p).
//  Sums a programmed count of signed products into a wide accumulator (dot-product / MAC tail).
//  Delivers the sum over a valid/ready handshake.
//  Reports signed overflow, with optional saturation.
// PARAMETERS
//  PROD_W  64  product width; matches the multiplier output p
//  ACC_W   72  accumulator width; must be >= PROD_W; product is sign-extended to ACC_W
//  LEN_W   8   width of the product-count field (max 255 products per run)
//  SAT     1   1: saturate to ACC_W signed min/max on overflow; 0: wrap (two's complement)
// PORTS
//  clk         in   1       clock; all logic on the rising edge
//  rst         in   1       synchronous, active-high reset
//  start       in   1       begin a run; sampled only in IDLE
//  len         in   LEN_W   number of products in the run; sampled with start
//  prod_valid  in   1       prod carries a product
//  prod        in   PROD_W  signed product from the multiplier
//  prod_ready  out  1       accumulator accepts prod this cycle
//  acc_valid   out  1       acc_out holds the final sum
//  acc_ready   in   1       downstream takes acc_out
//  acc_out     out  ACC_W   signed accumulated sum
//  overflow    out  1       sticky for the run; signed overflow occurred
//  busy        out  1       state != IDLE
// BEHAVIOUR
//  - Reset (rst=1 at clk edge):
//      state=IDLE; acc=0; cnt=0; overflow=0.
//      All outputs 0 from the next cycle. Any in-progress run is discarded; no acc_valid is issued.
//  - States: IDLE, ACCUM, DONE.
//  - IDLE:
//      prod_ready=0, acc_valid=0.
//      start=1, len!=0 -> acc=0, overflow=0, cnt=len, go to ACCUM.
//      start=1, len==0 -> acc=0, overflow=0, go to DONE (empty-sum result).
//  - ACCUM:
//      prod_ready=1 combinationally.
//      Transfer occurs when prod_valid & prod_ready: acc <= acc + sext(prod); cnt <= cnt-1.
//      Transfer while cnt==1 -> go to DONE.
//      prod_valid gaps stall the run with no state change. start is ignored.
//  - DONE:
//      acc_valid=1; acc_out=acc, held stable until acc_ready=1.
//      acc_valid & acc_ready -> go to IDLE. start is ignored, including in the handshake cycle.
//  - Latency: acc_valid rises the cycle after the last product transfer; one cycle after start when len==0.
//  - Throughput: one product per cycle.
//  - Overflow: detected when operand signs are equal and the sum sign differs.
//      Sets the sticky overflow flag.
//      SAT=1: acc clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1) and stays saturated-consistent.
//      SAT=0: acc wraps.
//      With defaults (72b, <=255 products) overflow is unreachable.
//  - overflow is valid alongside acc_valid and clears at the next accepted start or at rst.
//  - Simultaneous rst and any other input: rst wins.
// STRUCTURE
//  - booth_pkg:
//      state encoding localparams (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2)
//      PROD_W/ACC_W defaults
//      SEXT helper function
//  - One sub-module, booth_sat_add: combinational ACC_W signed add.
//      Outputs: sum, ovf.
//      SAT parameter selects clamp vs wrap.
//  - Top level: FSM, cnt register, acc register, handshake logic.
// TESTING
//  1. Mixed signs:
//     start, len=4; products 1500, 2064, -345, -750, one per cycle
//     -> acc_valid=1 one cycle after the 4th transfer, acc_out=2469 (0x9A5), overflow=0.
//  2. Back-pressure:
//     repeat test 1 with acc_ready=0 for 3 cycles
//     -> acc_valid and acc_out=2469 held stable; busy=1; return to IDLE the cycle after acc_ready=1.
//  3. Gaps and ignored start:
//     len=2; prod_valid pattern 1,0,0,1 with products 10 and 2500; start pulsed during ACCUM
//     -> acc_out=2510; start has no effect.
//  4. Empty run:
//     start, len=0 -> acc_valid=1 next cycle, acc_out=0, overflow=0.
//  5. Overflow, ACC_W=64:
//     SAT=1, len=2, products 0x7FFFFFFFFFFFFFFF and 1
//       -> acc_out=0x7FFFFFFFFFFFFFFF, overflow=1.
//     SAT=0, same products
//       -> acc_out=0x8000000000000000, overflow=1.
//  6. Reset mid-run:
//     len=4, rst asserted after 2 transfers
//     -> next cycle: busy=0, prod_ready=0, acc_valid=0, acc_out=0.
//     A new run with len=1, product -2250 -> acc_out=-2250.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the Booth product accumulator: default widths,
// controller state encoding and a sign-extension helper.
package booth_pkg;

  localparam int PROD_W_DEF = 64;
  localparam int ACC_W_DEF  = 72;
  localparam int LEN_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Widen a default-width product to the default accumulator width.
  function automatic logic [ACC_W_DEF-1:0] sext(input logic [PROD_W_DEF-1:0] p);
    return {{(ACC_W_DEF - PROD_W_DEF){p[PROD_W_DEF-1]}}, p};
  endfunction

endpackage

// File: rtl/booth_sat_add.sv
// Combinational signed adder of accumulator width. It flags signed overflow and
// either clamps to the signed range limits or lets the sum wrap.
module booth_sat_add #(
  parameter int ACC_W = 72,
  parameter bit SAT   = 1'b1
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W-1:0] raw;

  // Overflow means equal operand signs but a differing result sign; the clamp
  // direction follows the shared operand sign.
  always_comb begin
    raw = a + b;
    ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);
    sum = raw;
    if (ovf && SAT) begin
      sum = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/booth_product_accumulator.sv
// Sums a programmed number of signed multiplier products into a wide
// accumulator and hands the sum downstream over a valid/ready handshake.
module booth_product_accumulator
  import booth_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter bit SAT    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  output logic              prod_ready,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              overflow,
  output logic              busy
);

  state_t            state;
  state_t            state_next;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  prod_ext;
  logic [ACC_W-1:0]  sum;
  logic              ovf_add;
  logic              ovf_flag;
  logic [LEN_W-1:0]  cnt;
  logic              take;

  assign prod_ext = ACC_W'($signed(prod));

  booth_sat_add #(
    .ACC_W (ACC_W),
    .SAT   (SAT)
  ) u_add (
    .a   (acc),
    .b   (prod_ext),
    .sum (sum),
    .ovf (ovf_add)
  );

  // Next-state and handshake outputs; start only matters in IDLE and a product
  // transfers only while accumulating.
  always_comb begin
    state_next = state;
    prod_ready = 1'b0;
    acc_valid  = 1'b0;
    take       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        prod_ready = 1'b1;
        take       = prod_valid;
        if (prod_valid && cnt == LEN_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        acc_valid = 1'b1;
        if (acc_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset abandons any run without issuing a result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Accumulator, remaining-count and sticky overflow: cleared on an accepted
  // start, updated on every product transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      ovf_flag <= 1'b0;
    end else if (state == IDLE && start) begin
      acc      <= '0;
      cnt      <= len;
      ovf_flag <= 1'b0;
    end else if (take) begin
      acc      <= sum;
      cnt      <= cnt - LEN_W'(1);
      ovf_flag <= ovf_flag | ovf_add;
    end
  end

  assign acc_out  = acc;
  assign overflow = ovf_flag;
  assign busy     = (state != IDLE);

endmodule
